clause_dispatcher: RTL and testbench
====================================

// Module: clause_dispatcher
// PURPOSE
//  Consumer end of the clause latency buffer: takes the up-to-NUM_ENGINE clauses presented per cycle,
//  hands each to a free BCP engine through a per-engine one-entry slot, and returns the accepted count
//  the same cycle so the buffer can advance its head. Also forwards the chosen unit clause to all engines
//  and detects end of round: buffer empty, all slots empty, all engines idle.
// PARAMETERS
//  NUM_ENGINE  4   number of engines / clauses offered per cycle
//  CLA_W       96  clause width in bits (cla_t)
//  LIT_W       16  literal width in bits (lit_t)
//  CNT_W       16  width of the optional dispatch counter
// PORTS
//  clock                 in   1                      rising-edge clock
//  reset                 in   1                      asynchronous, active-low reset
//  start_in              in   1                      buffer start_out; qualifies clause_in/empty_in
//  empty_in              in   1                      buffer has no clauses left
//  clause_released_in    in   $clog2(NUM_ENGINE)+1   number of valid entries in clause_in, 0..NUM_ENGINE
//  clause_in             in   NUM_ENGINE*CLA_W       offered clauses; entry 0 is oldest
//  chosen_uc_in          in   LIT_W                  unit clause from the buffer
//  chosen_uc_valid_in    in   1                      chosen_uc_in valid
//  clause_received_out   out  $clog2(NUM_ENGINE)+1   clauses accepted this cycle (combinational)
//  eng_clause_out        out  NUM_ENGINE*CLA_W       per-engine clause from its slot
//  eng_valid_out         out  NUM_ENGINE             per-engine slot occupied
//  eng_ready_in          in   NUM_ENGINE             per-engine accept; slot frees when valid&ready
//  eng_busy_in           in   NUM_ENGINE             per-engine still propagating
//  eng_uc_out            out  LIT_W                  registered unit clause, broadcast to all engines
//  eng_uc_valid_out      out  1                      1-cycle pulse, one cycle after chosen_uc_valid_in
//  round_done_out        out  1                      1-cycle pulse at end of round
//  dispatch_count_out    out  CNT_W                  clauses dispatched this round (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0): state=IDLE; all slots empty; eng_valid_out=0, eng_clause_out=0, eng_uc_out=0,
//   eng_uc_valid_out=0, round_done_out=0, dispatch_count_out=0. clause_received_out=0 whenever reset is asserted.
//  FSM: IDLE -(start_in)-> RUN; RUN -(start_in & empty_in & no slot occupied)-> DRAIN;
//   DRAIN -(eng_busy_in==0 & no slot occupied)-> DONE; DONE -> IDLE unconditionally, round_done_out=1 in DONE only.
//   start_in deasserting in RUN holds RUN and accepts nothing.
//  Acceptance (RUN, start_in=1): F = number of slots empty at start of cycle (a slot draining this cycle
//   is not counted). k = min(clause_released_in, F). clause_in[j], j<k, loads the j-th empty slot in
//   ascending engine index. clause_received_out=k, combinational, same cycle; the buffer advances by k.
//   In IDLE, DRAIN and DONE: clause_received_out=0.
//  Slot: loaded slot shows eng_valid_out=1 from the next cycle; clears on the cycle after eng_valid_out&eng_ready_in.
//   Load and drain of the same slot in the same cycle never occur (drained slot is not free until the next cycle).
//  clause_released_in > NUM_ENGINE is illegal; it is clamped to NUM_ENGINE.
//  k never exceeds clause_released_in; a partial acceptance leaves the remainder in the buffer and it is
//   offered again in later cycles.
//  UC: chosen_uc_valid_in registers chosen_uc_in into eng_uc_out; eng_uc_valid_out pulses the next cycle,
//   in any state. eng_uc_out holds its value until the next valid.
//  Reset asserted mid-round: everything returns to reset values immediately; in-flight slot clauses are discarded.
// CONFIGURATION
//  DISPATCH_STATS_EN defined: dispatch_count_out increments by k each cycle in RUN and saturates at
//   2^CNT_W-1. It clears on the IDLE->RUN transition and holds its value through DRAIN, DONE and IDLE.
//  DISPATCH_STATS_EN not defined: no counter is built; dispatch_count_out is tied to 0.
// TESTING (NUM_ENGINE=4)
//  1 Reset: reset=0 with random inputs -> all outputs 0, state IDLE; release -> still IDLE until start_in.
//  2 Full accept: RUN, all slots empty, released=4 with clauses A..D -> received=4; next cycle eng_valid_out=4'b1111,
//    engine0..3 hold A..D.
//  3 Partial: slots 0 and 2 occupied, eng_ready_in=0, released=3 (E,F,G) -> received=2; E loads slot1, F loads slot3;
//    next cycle G is offered again at entry 0 and received=0.
//  4 Drain same cycle: slot1 valid&ready and the other slots occupied, released=1 -> received=0; slot1 free the
//    cycle after, then received=1.
//  5 End of round: empty_in=1, slots empty, eng_busy_in=4'b0100 for 3 cycles -> DRAIN holds 3 cycles;
//    round_done_out pulses exactly once; state returns to IDLE.
//  6 UC + stats: chosen_uc_valid_in with uc=0x0013 -> eng_uc_out=0x0013 with a 1-cycle pulse next cycle;
//    with DISPATCH_STATS_EN, 9 clauses accepted in a round -> dispatch_count_out=9; without the macro -> 0.

Source files
------------

// File: rtl/clause_dispatcher.sv
// clause_dispatcher: consumer end of the clause latency buffer.
// Hands up to NUM_ENGINE offered clauses per cycle to free per-engine one-entry slots,
// reports the accepted count combinationally, broadcasts the chosen unit clause and
// signals end of round once the buffer, all slots and all engines are quiet.
// Optional feature: define DISPATCH_STATS_EN to build the per-round dispatch counter.
module clause_dispatcher #(
    parameter int NUM_ENGINE = 4,
    parameter int CLA_W      = 96,
    parameter int LIT_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start_in,
    input  logic                          empty_in,
    input  logic [$clog2(NUM_ENGINE):0]   clause_released_in,
    input  logic [NUM_ENGINE*CLA_W-1:0]   clause_in,
    input  logic [LIT_W-1:0]              chosen_uc_in,
    input  logic                          chosen_uc_valid_in,
    output logic [$clog2(NUM_ENGINE):0]   clause_received_out,
    output logic [NUM_ENGINE*CLA_W-1:0]   eng_clause_out,
    output logic [NUM_ENGINE-1:0]         eng_valid_out,
    input  logic [NUM_ENGINE-1:0]         eng_ready_in,
    input  logic [NUM_ENGINE-1:0]         eng_busy_in,
    output logic [LIT_W-1:0]              eng_uc_out,
    output logic                          eng_uc_valid_out,
    output logic                          round_done_out,
    output logic [CNT_W-1:0]              dispatch_count_out
);

    localparam int RW = $clog2(NUM_ENGINE) + 1;
    localparam int IW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_ENGINE-1:0] slot_valid;
    logic [CLA_W-1:0]      slot_data [NUM_ENGINE];
    logic [CLA_W-1:0]      offered   [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] slot_load;
    logic [CLA_W-1:0]      load_data [NUM_ENGINE];
    logic [RW-1:0]         free_cnt;
    logic [RW-1:0]         released_clamped;
    logic [RW-1:0]         accept_k;
    logic [RW-1:0]         load_idx;
    logic                  accepting;
    logic                  slots_empty;
    logic [LIT_W-1:0]      uc_q;
    logic                  uc_valid_q;

    assign slots_empty = ~|slot_valid;

    // Split the packed offer bus into per-entry clauses, entry 0 oldest
    always_comb begin
        for (int i = 0; i < NUM_ENGINE; i++) begin
            offered[i] = clause_in[i*CLA_W +: CLA_W];
        end
    end

    // Count slots free at the start of the cycle and decide how many clauses to take
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (!slot_valid[i]) begin
                free_cnt = free_cnt + RW'(1);
            end
        end
        released_clamped = (clause_released_in > RW'(NUM_ENGINE)) ? RW'(NUM_ENGINE)
                                                                  : clause_released_in;
        accepting = reset && (state == RUN) && start_in;
        if (!accepting) begin
            accept_k = '0;
        end else if (released_clamped < free_cnt) begin
            accept_k = released_clamped;
        end else begin
            accept_k = free_cnt;
        end
    end

    assign clause_received_out = accept_k;

    // Steer the j-th accepted clause into the j-th free slot in ascending engine order
    always_comb begin
        load_idx  = '0;
        slot_load = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            load_data[i] = '0;
        end
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (!slot_valid[i] && (load_idx < accept_k)) begin
                slot_load[i] = 1'b1;
                load_data[i] = offered[load_idx[IW-1:0]];
                load_idx     = load_idx + RW'(1);
            end
        end
    end

    // Per-engine one-entry slots: a drained slot only becomes loadable a cycle later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_ENGINE; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                if (slot_valid[i] && eng_ready_in[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (slot_load[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_data[i]  <= load_data[i];
                end
            end
        end
    end

    // Pack slot contents onto the engine clause bus
    always_comb begin
        eng_clause_out = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            eng_clause_out[i*CLA_W +: CLA_W] = slot_data[i];
        end
    end

    assign eng_valid_out = slot_valid;

    // Round state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round sequencing: run while the buffer feeds us, drain until engines idle, pulse done
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start_in && empty_in && slots_empty) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((eng_busy_in == '0) && slots_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign round_done_out = (state == DONE);

    // Capture the chosen unit clause and pulse its valid one cycle later, in any state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uc_q       <= '0;
            uc_valid_q <= 1'b0;
        end else begin
            uc_valid_q <= chosen_uc_valid_in;
            if (chosen_uc_valid_in) begin
                uc_q <= chosen_uc_in;
            end
        end
    end

    assign eng_uc_out       = uc_q;
    assign eng_uc_valid_out = uc_valid_q;

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] count_q;
    logic [CNT_W:0]   count_sum;

    assign count_sum = {1'b0, count_q} + (CNT_W+1)'(accept_k);

    // Per-round dispatch counter: cleared when a round starts, saturating while running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if ((state == IDLE) && start_in) begin
            count_q <= '0;
        end else if (state == RUN) begin
            count_q <= count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
        end
    end

    assign dispatch_count_out = count_q;
`else
    assign dispatch_count_out = '0;
`endif

endmodule

// File: tb/tb_clause_dispatcher.sv
// tb_clause_dispatcher: directed self-checking bench for clause_dispatcher (NUM_ENGINE=4).
// Expected dispatch counts follow DISPATCH_STATS_EN when it is defined for the build.
module tb_clause_dispatcher;

    localparam int N    = 4;
    localparam int CW   = 96;
    localparam int LW   = 16;
    localparam int CNTW = 16;
`ifdef DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            start_in;
    logic            empty_in;
    logic [2:0]      clause_released_in;
    logic [N*CW-1:0] clause_in;
    logic [LW-1:0]   chosen_uc_in;
    logic            chosen_uc_valid_in;
    logic [2:0]      clause_received_out;
    logic [N*CW-1:0] eng_clause_out;
    logic [N-1:0]    eng_valid_out;
    logic [N-1:0]    eng_ready_in;
    logic [N-1:0]    eng_busy_in;
    logic [LW-1:0]   eng_uc_out;
    logic            eng_uc_valid_out;
    logic            round_done_out;
    logic [CNTW-1:0] dispatch_count_out;

    int n_cmp  = 0;
    int n_fail = 0;

    clause_dispatcher #(
        .NUM_ENGINE(N),
        .CLA_W(CW),
        .LIT_W(LW),
        .CNT_W(CNTW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start_in(start_in),
        .empty_in(empty_in),
        .clause_released_in(clause_released_in),
        .clause_in(clause_in),
        .chosen_uc_in(chosen_uc_in),
        .chosen_uc_valid_in(chosen_uc_valid_in),
        .clause_received_out(clause_received_out),
        .eng_clause_out(eng_clause_out),
        .eng_valid_out(eng_valid_out),
        .eng_ready_in(eng_ready_in),
        .eng_busy_in(eng_busy_in),
        .eng_uc_out(eng_uc_out),
        .eng_uc_valid_out(eng_uc_valid_out),
        .round_done_out(round_done_out),
        .dispatch_count_out(dispatch_count_out)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [CW-1:0] cl(input logic [7:0] t);
        return {12{t}};
    endfunction

    function automatic logic [CW-1:0] slot(input int i);
        return eng_clause_out[i*CW +: CW];
    endfunction

    function automatic logic [CNTW-1:0] cnt_exp(input int v);
        return STATS ? CNTW'(v) : '0;
    endfunction

    task automatic apply_stimulus(input logic [2:0] rel, input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                  input logic [CW-1:0] c2, input logic [CW-1:0] c3);
        clause_released_in = rel;
        clause_in          = {c3, c2, c1, c0};
    endtask

    initial begin
        // reset with random activity on every input
        reset              = 1'b0;
        start_in           = 1'b1;
        empty_in           = 1'($urandom);
        clause_released_in = 3'd4;
        for (int i = 0; i < 12; i++) clause_in[i*32 +: 32] = $urandom;
        chosen_uc_in       = 16'($urandom);
        chosen_uc_valid_in = 1'b1;
        eng_ready_in       = 4'($urandom);
        eng_busy_in        = 4'($urandom);
        repeat (3) tick();
        check_output("rst_valid", eng_valid_out, 4'b0000);
        for (int i = 0; i < N; i++) check_output($sformatf("rst_slot%0d", i), slot(i), '0);
        check_output("rst_uc", eng_uc_out, 16'h0000);
        check_output("rst_uc_valid", eng_uc_valid_out, 1'b0);
        check_output("rst_done", round_done_out, 1'b0);
        check_output("rst_count", dispatch_count_out, 16'h0000);
        check_output("rst_received", clause_received_out, 3'd0);

        // quiet inputs, release reset away from the edge
        start_in = 1'b0; empty_in = 1'b0; chosen_uc_in = '0; chosen_uc_valid_in = 1'b0;
        eng_ready_in = '0; eng_busy_in = '0;
        apply_stimulus(3'd4, cl(8'hA1), cl(8'hB2), cl(8'hC3), cl(8'hD4));
        settle();
        reset = 1'b1;
        tick();
        check_output("idle_no_start", clause_received_out, 3'd0);
        tick();
        check_output("idle_no_load", eng_valid_out, 4'b0000);
        start_in = 1'b1;
        settle();
        check_output("idle_start", clause_received_out, 3'd0);
        tick();

        // RUN without start_in accepts nothing
        start_in = 1'b0;
        settle();
        check_output("run_no_start", clause_received_out, 3'd0);
        tick();
        check_output("run_no_start_load", eng_valid_out, 4'b0000);

        // full accept of A..D
        start_in = 1'b1;
        settle();
        check_output("full_received", clause_received_out, 3'd4);
        tick();
        apply_stimulus(3'd0, '0, '0, '0, '0);
        settle();
        check_output("full_valid", eng_valid_out, 4'b1111);
        check_output("full_slot0", slot(0), cl(8'hA1));
        check_output("full_slot1", slot(1), cl(8'hB2));
        check_output("full_slot2", slot(2), cl(8'hC3));
        check_output("full_slot3", slot(3), cl(8'hD4));
        check_output("full_count", dispatch_count_out, cnt_exp(4));

        // partial: free slots 1 and 3, offer E,F,G
        eng_ready_in = 4'b1010;
        tick();
        eng_ready_in = 4'b0000;
        apply_stimulus(3'd3, cl(8'hE5), cl(8'hF6), cl(8'h67), cl(8'h99));
        settle();
        check_output("partial_valid_before", eng_valid_out, 4'b0101);
        check_output("partial_received", clause_received_out, 3'd2);
        tick();
        apply_stimulus(3'd1, cl(8'h67), '0, '0, '0);
        settle();
        check_output("partial_reoffer", clause_received_out, 3'd0);
        check_output("partial_valid", eng_valid_out, 4'b1111);
        check_output("partial_slot0", slot(0), cl(8'hA1));
        check_output("partial_slot1", slot(1), cl(8'hE5));
        check_output("partial_slot2", slot(2), cl(8'hC3));
        check_output("partial_slot3", slot(3), cl(8'hF6));

        // drain in the same cycle does not free the slot yet
        eng_ready_in = 4'b0010;
        settle();
        check_output("drain_same_cycle", clause_received_out, 3'd0);
        tick();
        eng_ready_in = 4'b0000;
        settle();
        check_output("after_drain_valid", eng_valid_out, 4'b1101);
        check_output("after_drain_received", clause_received_out, 3'd1);
        tick();
        apply_stimulus(3'd0, '0, '0, '0, '0);
        settle();
        check_output("after_drain_full", eng_valid_out, 4'b1111);
        check_output("after_drain_slot1", slot(1), cl(8'h67));
        check_output("after_drain_count", dispatch_count_out, cnt_exp(7));

        // illegal released count is clamped
        eng_ready_in = 4'b1111;
        tick();
        eng_ready_in = 4'b0000;
        apply_stimulus(3'd5, cl(8'h11), cl(8'h22), cl(8'h33), cl(8'h44));
        settle();
        check_output("clamp_received", clause_received_out, 3'd4);
        tick();
        apply_stimulus(3'd0, '0, '0, '0, '0);
        settle();
        check_output("clamp_slot0", slot(0), cl(8'h11));
        check_output("clamp_slot3", slot(3), cl(8'h44));

        // single clause lands in the lowest free engine
        eng_ready_in = 4'b1111;
        tick();
        eng_ready_in = 4'b0000;
        apply_stimulus(3'd1, cl(8'h5A), cl(8'hFF), '0, '0);
        settle();
        check_output("single_received", clause_received_out, 3'd1);
        tick();
        apply_stimulus(3'd0, '0, '0, '0, '0);
        settle();
        check_output("single_valid", eng_valid_out, 4'b0001);
        check_output("single_slot0", slot(0), cl(8'h5A));
        check_output("single_count", dispatch_count_out, cnt_exp(12));

        // end of round with one engine busy for 3 cycles
        eng_ready_in = 4'b0001;
        tick();
        eng_ready_in = 4'b0000;
        empty_in     = 1'b1;
        eng_busy_in  = 4'b0100;
        tick();
        apply_stimulus(3'd4, cl(8'h01), cl(8'h02), cl(8'h03), cl(8'h04));
        for (int i = 0; i < 3; i++) begin
            settle();
            check_output($sformatf("drain_received%0d", i), clause_received_out, 3'd0);
            check_output($sformatf("drain_done%0d", i), round_done_out, 1'b0);
            tick();
        end
        eng_busy_in = 4'b0000;
        settle();
        check_output("drain_last_done", round_done_out, 1'b0);
        tick();
        check_output("done_pulse", round_done_out, 1'b1);
        check_output("done_count", dispatch_count_out, cnt_exp(12));
        check_output("done_received", clause_received_out, 3'd0);
        tick();
        check_output("idle_after_done", round_done_out, 1'b0);
        check_output("idle_after_done_received", clause_received_out, 3'd0);
        start_in = 1'b0; empty_in = 1'b0;
        apply_stimulus(3'd0, '0, '0, '0, '0);
        tick();
        check_output("done_once", round_done_out, 1'b0);
        check_output("hold_count", dispatch_count_out, cnt_exp(12));

        // unit clause broadcast
        chosen_uc_in       = 16'h0013;
        chosen_uc_valid_in = 1'b1;
        settle();
        check_output("uc_not_early", eng_uc_valid_out, 1'b0);
        tick();
        chosen_uc_valid_in = 1'b0;
        chosen_uc_in       = 16'hBEEF;
        settle();
        check_output("uc_value", eng_uc_out, 16'h0013);
        check_output("uc_pulse", eng_uc_valid_out, 1'b1);
        tick();
        check_output("uc_pulse_end", eng_uc_valid_out, 1'b0);
        check_output("uc_hold", eng_uc_out, 16'h0013);

        // new round clears the counter
        start_in = 1'b1;
        apply_stimulus(3'd2, cl(8'h71), cl(8'h72), '0, '0);
        tick();
        check_output("new_round_clear", dispatch_count_out, 16'h0000);
        check_output("new_round_received", clause_received_out, 3'd2);
        tick();
        apply_stimulus(3'd4, cl(8'h81), cl(8'h82), cl(8'h83), cl(8'h84));
        settle();
        check_output("new_round_valid", eng_valid_out, 4'b0011);
        check_output("new_round_count", dispatch_count_out, cnt_exp(2));
        check_output("new_round_received2", clause_received_out, 3'd2);

        // reset mid-round discards everything immediately
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_valid", eng_valid_out, 4'b0000);
        check_output("midrst_received", clause_received_out, 3'd0);
        check_output("midrst_slot0", slot(0), '0);
        check_output("midrst_count", dispatch_count_out, 16'h0000);
        check_output("midrst_uc", eng_uc_out, 16'h0000);
        tick();
        start_in = 1'b0;
        reset    = 1'b1;
        tick();
        check_output("post_rst_valid", eng_valid_out, 4'b0000);
        check_output("post_rst_received", clause_received_out, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
